// File: rtl/instr_stream_decoder.sv
// Streaming draw-instruction decoder: assembles LSB-first words into one instruction,
// decodes shape/vertex/colour/misc/opcode fields into a valid/ready output register.
module instr_stream_decoder #(
  parameter int width     = 4,
  parameter int height    = 3,
  parameter int num_pts   = 3,
  parameter int misc_amt  = 9,
  parameter int op_size   = 1,
  parameter int word_size = 8,
  localparam int R_OFF    = 1 + num_pts * (width + height),
  localparam int MISC_OFF = R_OFF + 24,
  localparam int OP_OFF   = MISC_OFF + misc_amt,
  localparam int L        = OP_OFF + op_size,
  localparam int W        = (L + word_size - 1) / word_size,
  localparam int CW       = (W > 1) ? $clog2(W) : 1,
  localparam int AW       = W * word_size,
  localparam int XW       = num_pts * width,
  localparam int YW       = num_pts * height
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [word_size-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 shape,
  output logic [XW-1:0]        xs,
  output logic [YW-1:0]        ys,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b,
  output logic [misc_amt-1:0]  misc,
  output logic [op_size-1:0]   op_code,
  output logic [CW-1:0]        words_pending
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       asm_q, asm_d;
  logic [AW-1:0]       asm_full_s, src_s;
  logic                out_valid_q, out_valid_d;
  logic                word_ready_s, accept_s, last_s, pop_s, stage_free_s, load_s;

  logic                shape_q;
  logic [XW-1:0]       xs_q;
  logic [YW-1:0]       ys_q;
  logic [7:0]          r_q, g_q, b_q;
  logic [misc_amt-1:0] misc_q;
  logic [op_size-1:0]  op_q;

  logic                dec_shape_s;
  logic [XW-1:0]       dec_xs_s;
  logic [YW-1:0]       dec_ys_s;
  logic [7:0]          dec_r_s, dec_g_s, dec_b_s;
  logic [misc_amt-1:0] dec_misc_s;
  logic [op_size-1:0]  dec_op_s;

  assign word_ready_s = (state_q == ST_COLLECT);
  assign accept_s     = word_valid & word_ready_s;
  assign last_s       = (cnt_q == CW'(W - 1));
  assign pop_s        = out_valid_q & out_ready;
  assign stage_free_s = ~out_valid_q | out_ready;

  // Assembly image with the current word dropped into slot cnt, so a completing
  // word can be decoded in the same cycle it arrives.
  always_comb begin
    asm_full_s = asm_q;
    for (int k = 0; k < W; k++) begin
      if (cnt_q == CW'(k)) begin
        asm_full_s[k*word_size +: word_size] = word_in;
      end else begin
        asm_full_s[k*word_size +: word_size] = asm_q[k*word_size +: word_size];
      end
    end
  end

  // Next-state logic for collection FSM, word counter and output-stage valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    load_s      = 1'b0;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          asm_d = asm_full_s;
          if (last_s) begin
            cnt_d = {CW{1'b0}};
            if (stage_free_s) begin
              load_s = 1'b1;
            end else begin
              state_d = ST_FULL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          asm_d = asm_q;
        end
      end
      ST_FULL: begin
        if (stage_free_s) begin
          load_s  = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    // flush outranks every accept and pop; the word offered this cycle is lost
    if (flush) begin
      state_d     = ST_COLLECT;
      cnt_d       = {CW{1'b0}};
      asm_d       = asm_q;
      load_s      = 1'b0;
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
    end else if (pop_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign src_s = (state_q == ST_FULL) ? asm_q : asm_full_s;

  // Field extraction from the completed instruction image.
  always_comb begin
    dec_shape_s = src_s[0];
    dec_xs_s    = {XW{1'b0}};
    dec_ys_s    = {YW{1'b0}};
    for (int i = 0; i < num_pts; i++) begin
      dec_xs_s[i*width +: width]   = src_s[1 + i*(width+height) +: width];
      dec_ys_s[i*height +: height] = src_s[1 + i*(width+height) + width +: height];
    end
    dec_r_s    = src_s[R_OFF +: 8];
    dec_g_s    = src_s[R_OFF + 8 +: 8];
    dec_b_s    = src_s[R_OFF + 16 +: 8];
    dec_misc_s = src_s[MISC_OFF +: misc_amt];
    dec_op_s   = src_s[OP_OFF +: op_size];
  end

  generate
    if (AW > L) begin : g_pad
      logic pad_unused_s;
      assign pad_unused_s = ^src_s[AW-1:L];
    end
  endgenerate

  // Control state, counter, assembly buffer and output valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= {CW{1'b0}};
      asm_q       <= {AW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output field register; only written on a load so fields hold under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shape_q <= 1'b0;
      xs_q    <= {XW{1'b0}};
      ys_q    <= {YW{1'b0}};
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
      misc_q  <= {misc_amt{1'b0}};
      op_q    <= {op_size{1'b0}};
    end else if (load_s) begin
      shape_q <= dec_shape_s;
      xs_q    <= dec_xs_s;
      ys_q    <= dec_ys_s;
      r_q     <= dec_r_s;
      g_q     <= dec_g_s;
      b_q     <= dec_b_s;
      misc_q  <= dec_misc_s;
      op_q    <= dec_op_s;
    end
  end

  assign word_ready    = word_ready_s;
  assign out_valid     = out_valid_q;
  assign shape         = shape_q;
  assign xs            = xs_q;
  assign ys            = ys_q;
  assign r             = r_q;
  assign g             = g_q;
  assign b             = b_q;
  assign misc          = misc_q;
  assign op_code       = op_q;
  assign words_pending = cnt_q;

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Directed bench for instr_stream_decoder: default config (A), 16-bit bus with
// padding (B) and a 4-vertex 6x5 config (C).
module tb_instr_stream_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- DUT A: defaults, W=7 ----------------
  logic        a_flush, a_word_valid, a_word_ready, a_out_valid, a_out_ready, a_shape;
  logic [7:0]  a_word_in, a_r, a_g, a_b;
  logic [11:0] a_xs;
  logic [8:0]  a_ys, a_misc;
  logic [0:0]  a_op;
  logic [2:0]  a_pend;

  instr_stream_decoder dut_a (
    .clk(clk), .reset_n(rst_n), .flush(a_flush), .word_in(a_word_in),
    .word_valid(a_word_valid), .word_ready(a_word_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .shape(a_shape), .xs(a_xs), .ys(a_ys), .r(a_r), .g(a_g),
    .b(a_b), .misc(a_misc), .op_code(a_op), .words_pending(a_pend)
  );

  // ---------------- DUT B: word_size=16, W=4, 8 pad bits ----------------
  logic        b_flush, b_word_valid, b_word_ready, b_out_valid, b_out_ready, b_shape;
  logic [15:0] b_word_in;
  logic [7:0]  b_r, b_g, b_b;
  logic [11:0] b_xs;
  logic [8:0]  b_ys, b_misc;
  logic [0:0]  b_op;
  logic [1:0]  b_pend;

  instr_stream_decoder #(.word_size(16)) dut_b (
    .clk(clk), .reset_n(rst_n), .flush(b_flush), .word_in(b_word_in),
    .word_valid(b_word_valid), .word_ready(b_word_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .shape(b_shape), .xs(b_xs), .ys(b_ys), .r(b_r), .g(b_g),
    .b(b_b), .misc(b_misc), .op_code(b_op), .words_pending(b_pend)
  );

  // ---------------- DUT C: num_pts=4, width=6, height=5, L=79, W=10 ----------------
  logic        c_flush, c_word_valid, c_word_ready, c_out_valid, c_out_ready, c_shape;
  logic [7:0]  c_word_in, c_r, c_g, c_b;
  logic [23:0] c_xs;
  logic [19:0] c_ys;
  logic [8:0]  c_misc;
  logic [0:0]  c_op;
  logic [3:0]  c_pend;

  instr_stream_decoder #(.num_pts(4), .width(6), .height(5)) dut_c (
    .clk(clk), .reset_n(rst_n), .flush(c_flush), .word_in(c_word_in),
    .word_valid(c_word_valid), .word_ready(c_word_ready), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .shape(c_shape), .xs(c_xs), .ys(c_ys), .r(c_r), .g(c_g),
    .b(c_b), .misc(c_misc), .op_code(c_op), .words_pending(c_pend)
  );

  typedef struct {
    logic [55:0] instr;
    logic        shape;
    logic [11:0] xs;
    logic [8:0]  ys;
    logic [7:0]  r, g, b;
    logic [8:0]  misc;
    logic        op;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [55:0] pack_a(vec_t v);
    logic [55:0] p;
    p = 56'd0;
    p[0] = v.shape;
    for (int i = 0; i < 3; i++) begin
      p[1 + i*7 +: 4] = v.xs[i*4 +: 4];
      p[5 + i*7 +: 3] = v.ys[i*3 +: 3];
    end
    p[22 +: 8] = v.r;
    p[30 +: 8] = v.g;
    p[38 +: 8] = v.b;
    p[46 +: 9] = v.misc;
    p[55]      = v.op;
    return p;
  endfunction

  function automatic logic [55:0] exp_fields(vec_t v);
    return {v.shape, v.xs, v.ys, v.r, v.g, v.b, v.misc, v.op};
  endfunction

  function automatic logic [55:0] fields_a();
    return {a_shape, a_xs, a_ys, a_r, a_g, a_b, a_misc, a_op};
  endfunction

  function automatic logic [55:0] fields_b();
    return {b_shape, b_xs, b_ys, b_r, b_g, b_b, b_misc, b_op};
  endfunction

  function automatic logic [79:0] pack_c(logic sh, logic [23:0] xs, logic [19:0] ys,
                                         logic [7:0] r, logic [7:0] g, logic [7:0] b,
                                         logic [8:0] m, logic op);
    logic [79:0] p;
    p     = 80'd0;
    p[79] = 1'b1;
    p[0]  = sh;
    for (int i = 0; i < 4; i++) begin
      p[1 + i*11 +: 6] = xs[i*6 +: 6];
      p[7 + i*11 +: 5] = ys[i*5 +: 5];
    end
    p[45 +: 8] = r;
    p[53 +: 8] = g;
    p[61 +: 8] = b;
    p[69 +: 9] = m;
    p[78]      = op;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  // Pop monitor for DUT A
  int          cyc = 0;
  logic [55:0] popped[$];
  int          pop_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_out_valid && a_out_ready) begin
      popped.push_back(fields_a());
      pop_cyc.push_back(cyc);
    end
  end

  task automatic send_a(input logic [7:0] w);
    bit acc = 1'b0;
    a_word_in    = w;
    a_word_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      acc = a_word_ready;
      @(posedge clk);
      #1;
    end
    a_word_valid = 1'b0;
    if (!acc) timeout("send_a");
  endtask

  task automatic send_instr_a(input logic [55:0] ins);
    for (int k = 0; k < 7; k++) send_a(ins[k*8 +: 8]);
  endtask

  task automatic send_b(input logic [15:0] w);
    bit acc = 1'b0;
    b_word_in    = w;
    b_word_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      acc = b_word_ready;
      @(posedge clk);
      #1;
    end
    b_word_valid = 1'b0;
    if (!acc) timeout("send_b");
  endtask

  task automatic send_c(input logic [7:0] w);
    bit acc = 1'b0;
    c_word_in    = w;
    c_word_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      acc = c_word_ready;
      @(posedge clk);
      #1;
    end
    c_word_valid = 1'b0;
    if (!acc) timeout("send_c");
  endtask

  task automatic pop_a();
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
  endtask

  logic [63:0] ins_b;
  logic [79:0] ins_c1, ins_c2;

  initial begin
    // hand-packed test-plan instruction, then further vectors packed by pack_a
    tbl[0] = '{56'hE97FD56A987F4B, 1'b1, 12'h0F5, 9'h0FA, 8'hAA, 8'h55, 8'hFF, 9'h1A5, 1'b1};
    tbl[1] = '{56'd0, 1'b0, 12'hA3C, 9'h1C5, 8'h01, 8'h80, 8'h00, 9'h000, 1'b0};
    tbl[2] = '{56'd0, 1'b1, 12'hFFF, 9'h1FF, 8'hFF, 8'hFF, 8'hFF, 9'h1FF, 1'b1};
    tbl[3] = '{56'd0, 1'b0, 12'h5A5, 9'h0AA, 8'h3C, 8'hC3, 8'h99, 9'h155, 1'b1};
    for (int i = 1; i < 4; i++) tbl[i].instr = pack_a(tbl[i]);

    rst_n = 1'b0;
    a_flush = 1'b0; a_word_valid = 1'b0; a_word_in = 8'h00; a_out_ready = 1'b0;
    b_flush = 1'b0; b_word_valid = 1'b0; b_word_in = 16'h0000; b_out_ready = 1'b0;
    c_flush = 1'b0; c_word_valid = 1'b0; c_word_in = 8'h00; c_out_ready = 1'b0;
    #12;
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_word_ready", a_word_ready, 1'b1);
    check("rst_pending", a_pend, 3'd0);
    check("rst_fields", fields_a(), 56'd0);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    check("rst_c_out_valid", c_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: out_valid appears only after the 7th accepted word
    for (int k = 0; k < 6; k++) send_a(tbl[0].instr[k*8 +: 8]);
    check("lat_pending6", a_pend, 3'd6);
    check("lat_valid_early", a_out_valid, 1'b0);
    send_a(tbl[0].instr[48 +: 8]);
    check("lat_valid", a_out_valid, 1'b1);
    check("lat_pending0", a_pend, 3'd0);
    check("v0_shape", a_shape, 1'b1);
    check("v0_xs", a_xs, 12'h0F5);
    check("v0_ys", a_ys, 9'h0FA);
    check("v0_r", a_r, 8'hAA);
    check("v0_g", a_g, 8'h55);
    check("v0_b", a_b, 8'hFF);
    check("v0_misc", a_misc, 9'h1A5);
    check("v0_op", a_op, 1'b1);
    pop_a();
    check("pop_clears_valid", a_out_valid, 1'b0);

    // Table-driven decode
    for (int i = 0; i < 4; i++) begin
      send_instr_a(tbl[i].instr);
      check($sformatf("tbl%0d_valid", i), a_out_valid, 1'b1);
      check($sformatf("tbl%0d_fields", i), fields_a(), exp_fields(tbl[i]));
      pop_a();
    end

    // Continuous stream with out_ready=1: one pop every 7 cycles
    popped.delete();
    pop_cyc.delete();
    a_out_ready = 1'b1;
    for (int i = 1; i < 4; i++) send_instr_a(tbl[i].instr);
    repeat (3) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    check("stream_count", popped.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < popped.size()) check($sformatf("stream_data%0d", i), popped[i], exp_fields(tbl[i+1]));
    end
    for (int i = 1; i < 3; i++) begin
      if (i < pop_cyc.size()) check($sformatf("stream_gap%0d", i), pop_cyc[i] - pop_cyc[i-1], 7);
    end

    // Backpressure: two instructions buffered, then word_ready drops
    popped.delete();
    send_instr_a(tbl[1].instr);
    send_instr_a(tbl[2].instr);
    check("bp_word_ready", a_word_ready, 1'b0);
    check("bp_valid", a_out_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_word_ready_hold", a_word_ready, 1'b0);
    check("bp_fields_hold", fields_a(), exp_fields(tbl[1]));
    a_out_ready  = 1'b1;
    a_word_in    = tbl[3].instr[7:0];
    a_word_valid = 1'b1;
    @(posedge clk);
    #1;
    check("bp_popload_valid", a_out_valid, 1'b1);
    check("bp_popload_fields", fields_a(), exp_fields(tbl[2]));
    check("bp_ready_back", a_word_ready, 1'b1);
    check("bp_word_not_taken", a_pend, 3'd0);
    send_instr_a(tbl[3].instr);
    repeat (3) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    check("bp_count", popped.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < popped.size()) check($sformatf("bp_order%0d", i), popped[i], exp_fields(tbl[i+1]));
    end

    // Flush with a full output stage and a partial instruction
    send_instr_a(tbl[0].instr);
    for (int k = 0; k < 3; k++) send_a(tbl[3].instr[k*8 +: 8]);
    check("fl_pending3", a_pend, 3'd3);
    check("fl_valid_before", a_out_valid, 1'b1);
    a_flush      = 1'b1;
    a_word_valid = 1'b1;
    a_word_in    = 8'h5C;
    a_out_ready  = 1'b1;
    @(posedge clk);
    #1;
    a_flush      = 1'b0;
    a_word_valid = 1'b0;
    a_out_ready  = 1'b0;
    check("fl_pending0", a_pend, 3'd0);
    check("fl_valid", a_out_valid, 1'b0);
    send_instr_a(tbl[3].instr);
    check("fl_fresh_valid", a_out_valid, 1'b1);
    check("fl_fresh_fields", fields_a(), exp_fields(tbl[3]));
    pop_a();

    // DUT B: 16-bit words, pad byte all ones
    ins_b = {8'hFF, tbl[0].instr};
    for (int k = 0; k < 3; k++) send_b(ins_b[k*16 +: 16]);
    check("b_pending3", b_pend, 2'd3);
    send_b(ins_b[48 +: 16]);
    check("b_valid", b_out_valid, 1'b1);
    check("b_fields", fields_b(), exp_fields(tbl[0]));
    b_out_ready = 1'b1;
    ins_b = {8'hFF, tbl[3].instr};
    for (int k = 0; k < 4; k++) send_b(ins_b[k*16 +: 16]);
    b_out_ready = 1'b0;
    check("b_fields2", fields_b(), exp_fields(tbl[3]));

    // DUT C: 4 vertices, 6-bit x, 5-bit y
    ins_c1 = pack_c(1'b0, {6'd63, 6'd21, 6'd40, 6'd3}, {5'd9, 5'd17, 5'd0, 5'd31},
                    8'd12, 8'd34, 8'd56, 9'h0F0, 1'b0);
    ins_c2 = pack_c(1'b1, {6'd7, 6'd0, 6'd33, 6'd62}, {5'd30, 5'd1, 5'd16, 5'd5},
                    8'hE1, 8'h1E, 8'h77, 9'h10B, 1'b1);
    for (int k = 0; k < 10; k++) send_c(ins_c1[k*8 +: 8]);
    check("c_valid", c_out_valid, 1'b1);
    check("c_shape", c_shape, 1'b0);
    check("c_xs", c_xs, {6'd63, 6'd21, 6'd40, 6'd3});
    check("c_ys", c_ys, {5'd9, 5'd17, 5'd0, 5'd31});
    check("c_rgb", {c_r, c_g, c_b}, {8'd12, 8'd34, 8'd56});
    check("c_misc_op", {c_misc, c_op}, {9'h0F0, 1'b0});
    for (int k = 0; k < 4; k++) send_c(ins_c2[k*8 +: 8]);
    check("c_pending4", c_pend, 4'd4);

    // Async reset mid-stream, asserted away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", c_out_valid, 1'b0);
    check("ar_xs", c_xs, 24'd0);
    check("ar_ys", c_ys, 20'd0);
    check("ar_pending", c_pend, 4'd0);
    check("ar_word_ready", c_word_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) send_c(ins_c2[k*8 +: 8]);
    check("ar_no_stale_valid", c_out_valid, 1'b0);
    send_c(ins_c2[72 +: 8]);
    check("ar_fresh_valid", c_out_valid, 1'b1);
    check("ar_fresh_xs", c_xs, {6'd7, 6'd0, 6'd33, 6'd62});
    check("ar_fresh_ys", c_ys, {5'd30, 5'd1, 5'd16, 5'd5});
    check("ar_fresh_rest", {c_shape, c_r, c_g, c_b, c_misc, c_op},
          {1'b1, 8'hE1, 8'h1E, 8'h77, 9'h10B, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
